// File: rtl/imm_decode_stage_if.sv
// Bus bundle for the immediate-decode stage: upstream valid/ready with
// instruction, flush and downstream valid/ready with the decoded entry.
interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) ();
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instr;
    logic             i_signext;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_instr;
    logic [XLEN-1:0]  o_imm;
    logic [2:0]       o_fmt;
    logic             o_illegal;
    logic [CNT_W-1:0] o_ill_cnt;

    // The decode stage itself
    modport slave (
        input  i_flush, i_valid, i_instr, i_signext, i_ready,
        output o_ready, o_valid, o_instr, o_imm, o_fmt, o_illegal, o_ill_cnt
    );

    // Whatever drives the stage (fetch side plus execute-side ready)
    modport master (
        output i_flush, i_valid, i_instr, i_signext, i_ready,
        input  o_ready, o_valid, o_instr, o_imm, o_fmt, o_illegal, o_ill_cnt
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between fetch and execute.
// Two storage entries (OUT + SKID) give full throughput with a registered
// o_ready. XLEN must be 32 or 64.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    imm_decode_stage_if.slave     stage
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_SH  = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;
    logic             sx_s;
    logic [31:0]      dec_low_s;
    logic             dec_fill_s;
    entry_t           dec_s;
    logic             accept_s;
    logic             out_free_s;
    entry_t           out_r;
    entry_t           skid_r;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic [CNT_W-1:0] ill_cnt_r;

    assign opcode_s   = stage.i_instr[6:0];
    assign funct3_s   = stage.i_instr[14:12];
    assign sx_s       = stage.i_instr[31] & stage.i_signext;
    // Flush wins over accept, so a flushed offer never lands or counts.
    assign accept_s   = stage.i_valid & ~skid_valid_r & ~stage.i_flush;
    assign out_free_s = ~out_valid_r | stage.i_ready;

    // Decode the offered instruction: low 32 bits plus an upper fill bit for XLEN=64
    always_comb begin
        dec_low_s  = 32'd0;
        dec_fill_s = 1'b0;
        dec_s.fmt     = FMT_ILL;
        dec_s.illegal = 1'b1;
        case (opcode_s)
            OPC_LOAD, OPC_JALR: begin
                dec_low_s  = {{20{sx_s}}, stage.i_instr[31:20]};
                dec_fill_s = sx_s;
                dec_s.fmt  = FMT_I;
                dec_s.illegal = 1'b0;
            end
            OPC_OPIMM: begin
                dec_s.illegal = 1'b0;
                if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    dec_fmt_shamt(dec_low_s, dec_fill_s, dec_s.fmt, XLEN == 64);
                end else begin
                    dec_low_s  = {{20{sx_s}}, stage.i_instr[31:20]};
                    dec_fill_s = sx_s;
                    dec_s.fmt  = FMT_I;
                end
            end
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    dec_s.illegal = 1'b0;
                    if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                        dec_fmt_shamt(dec_low_s, dec_fill_s, dec_s.fmt, 1'b0);
                    end else begin
                        dec_low_s  = {{20{sx_s}}, stage.i_instr[31:20]};
                        dec_fill_s = sx_s;
                        dec_s.fmt  = FMT_I;
                    end
                end else begin
                    dec_s.illegal = 1'b1;
                    dec_s.fmt     = FMT_ILL;
                end
            end
            OPC_STORE: begin
                dec_low_s  = {{20{sx_s}}, stage.i_instr[31:25], stage.i_instr[11:7]};
                dec_fill_s = sx_s;
                dec_s.fmt  = FMT_S;
                dec_s.illegal = 1'b0;
            end
            OPC_BRANCH: begin
                dec_low_s  = {{20{sx_s}}, stage.i_instr[7], stage.i_instr[30:25],
                              stage.i_instr[11:8], 1'b0};
                dec_fill_s = sx_s;
                dec_s.fmt  = FMT_B;
                dec_s.illegal = 1'b0;
            end
            OPC_JAL: begin
                dec_low_s  = {{12{sx_s}}, stage.i_instr[19:12], stage.i_instr[20],
                              stage.i_instr[30:21], 1'b0};
                dec_fill_s = sx_s;
                dec_s.fmt  = FMT_J;
                dec_s.illegal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                // Upper half on RV64 always follows bit 31, independent of i_signext.
                dec_low_s  = {stage.i_instr[31:12], 12'd0};
                dec_fill_s = stage.i_instr[31];
                dec_s.fmt  = FMT_U;
                dec_s.illegal = 1'b0;
            end
            OPC_OP: begin
                dec_s.fmt     = FMT_R;
                dec_s.illegal = 1'b0;
            end
            OPC_OP32: begin
                if (XLEN == 64) begin
                    dec_s.fmt     = FMT_R;
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.fmt     = FMT_ILL;
                    dec_s.illegal = 1'b1;
                end
            end
            default: begin
                dec_s.fmt     = FMT_ILL;
                dec_s.illegal = 1'b1;
            end
        endcase
        dec_s.instr        = stage.i_instr;
        dec_s.imm          = {XLEN{dec_fill_s}};
        dec_s.imm[31:0]    = dec_low_s;
    end

    // Shift-amount immediate: zero-extended, 6 bits wide only for full RV64 shifts
    task automatic dec_fmt_shamt(output logic [31:0] low, output logic fill,
                                 output logic [2:0] fmt, input logic wide);
        if (wide) begin
            low = {26'd0, stage.i_instr[25:20]};
        end else begin
            low = {27'd0, stage.i_instr[24:20]};
        end
        fill = 1'b0;
        fmt  = FMT_SH;
    endtask

    // OUT/SKID entry storage: skid drains first so ordering stays FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_r        <= '0;
            skid_r       <= '0;
        end else if (stage.i_flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end
    end

    // Saturating count of accepted illegal entries; flush does not clear it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ill_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && dec_s.illegal && (ill_cnt_r != {CNT_W{1'b1}})) begin
            ill_cnt_r <= ill_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stage.o_ready   = ~skid_valid_r;
    assign stage.o_valid   = out_valid_r;
    assign stage.o_instr   = out_r.instr;
    assign stage.o_imm     = out_r.imm;
    assign stage.o_fmt     = out_r.fmt;
    assign stage.o_illegal = out_r.illegal;
    assign stage.o_ill_cnt = ill_cnt_r;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench: an RV32 instance, an RV64 instance and a
// small-counter RV32 instance share clock and reset.
module tb_imm_decode_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    imm_decode_stage_if #(.XLEN(32), .CNT_W(16)) bus32 ();
    imm_decode_stage_if #(.XLEN(64), .CNT_W(16)) bus64 ();
    imm_decode_stage_if #(.XLEN(32), .CNT_W(2))  bussat ();

    imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32  (.i_clk(clk), .i_rst(rst), .stage(bus32));
    imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64  (.i_clk(clk), .i_rst(rst), .stage(bus64));
    imm_decode_stage #(.XLEN(32), .CNT_W(2))  dutsat (.i_clk(clk), .i_rst(rst), .stage(bussat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push32(input logic [31:0] ins, input logic sx);
        bus32.i_valid   = 1'b1;
        bus32.i_instr   = ins;
        bus32.i_signext = sx;
        bus32.i_ready   = 1'b1;
        tick();
        bus32.i_valid   = 1'b0;
    endtask

    task automatic push64(input logic [31:0] ins, input logic sx);
        bus64.i_valid   = 1'b1;
        bus64.i_instr   = ins;
        bus64.i_signext = sx;
        bus64.i_ready   = 1'b1;
        tick();
        bus64.i_valid   = 1'b0;
    endtask

    task automatic push_sat(input logic [31:0] ins);
        bussat.i_valid   = 1'b1;
        bussat.i_instr   = ins;
        bussat.i_signext = 1'b1;
        bussat.i_ready   = 1'b1;
        tick();
        bussat.i_valid   = 1'b0;
    endtask

    task automatic check32(input string tag, input logic [31:0] ins, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic ill);
        check_eq({tag, ".valid"}, {63'd0, bus32.o_valid}, 64'd1);
        check_eq({tag, ".instr"}, {32'd0, bus32.o_instr}, {32'd0, ins});
        check_eq({tag, ".imm"},   {32'd0, bus32.o_imm}, imm);
        check_eq({tag, ".fmt"},   {61'd0, bus32.o_fmt}, {61'd0, fmt});
        check_eq({tag, ".ill"},   {63'd0, bus32.o_illegal}, {63'd0, ill});
    endtask

    task automatic check64(input string tag, input logic [63:0] imm, input logic [2:0] fmt,
                           input logic ill);
        check_eq({tag, ".valid"}, {63'd0, bus64.o_valid}, 64'd1);
        check_eq({tag, ".imm"},   bus64.o_imm, imm);
        check_eq({tag, ".fmt"},   {61'd0, bus64.o_fmt}, {61'd0, fmt});
        check_eq({tag, ".ill"},   {63'd0, bus64.o_illegal}, {63'd0, ill});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus32.i_flush = 1'b0;  bus32.i_valid = 1'b0;  bus32.i_instr = 32'd0;
        bus32.i_signext = 1'b1; bus32.i_ready = 1'b1;
        bus64.i_flush = 1'b0;  bus64.i_valid = 1'b0;  bus64.i_instr = 32'd0;
        bus64.i_signext = 1'b1; bus64.i_ready = 1'b1;
        bussat.i_flush = 1'b0; bussat.i_valid = 1'b0; bussat.i_instr = 32'd0;
        bussat.i_signext = 1'b1; bussat.i_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check_eq("rst.valid", {63'd0, bus32.o_valid}, 64'd0);
        check_eq("rst.ready", {63'd0, bus32.o_ready}, 64'd1);
        check_eq("rst.instr", {32'd0, bus32.o_instr}, 64'd0);
        check_eq("rst.imm",   {32'd0, bus32.o_imm}, 64'd0);
        check_eq("rst.fmt",   {61'd0, bus32.o_fmt}, 64'd0);
        check_eq("rst.ill",   {63'd0, bus32.o_illegal}, 64'd0);
        check_eq("rst.cnt",   {48'd0, bus32.o_ill_cnt}, 64'd0);
        rst = 1'b0;

        // RV32 decode, streamed back to back
        push32(32'hFFF00093, 1'b1); check32("addi_sx", 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0);
        push32(32'hFFF00093, 1'b0); check32("addi_zx", 32'hFFF00093, 64'h00000FFF, 3'd1, 1'b0);
        push32(32'h01F09093, 1'b1); check32("slli31",  32'h01F09093, 64'd31, 3'd6, 1'b0);
        push32(32'hFE112E23, 1'b1); check32("sw_m4",   32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0);
        push32(32'hFF9FF06F, 1'b1); check32("jal_m8",  32'hFF9FF06F, 64'hFFFFFFF8, 3'd5, 1'b0);
        push32(32'hFE000EE3, 1'b0); check32("beq_zx",  32'hFE000EE3, 64'h00000FFC, 3'd3, 1'b0);
        push32(32'h12345037, 1'b1); check32("lui",     32'h12345037, 64'h12345000, 3'd4, 1'b0);
        push32(32'h002081B3, 1'b1); check32("add",     32'h002081B3, 64'd0, 3'd0, 1'b0);
        tick();
        check_eq("drain.valid", {63'd0, bus32.o_valid}, 64'd0);

        // Backpressure: OUT and SKID fill, third offer held upstream
        bus32.i_ready = 1'b0;
        bus32.i_valid = 1'b1;
        bus32.i_instr = 32'h00100093;
        tick();
        bus32.i_instr = 32'h00200093;
        tick();
        check_eq("bp.ready0", {63'd0, bus32.o_ready}, 64'd0);
        bus32.i_instr = 32'h00300093;
        tick();
        check_eq("bp.hold_ready", {63'd0, bus32.o_ready}, 64'd0);
        check_eq("bp.hold_instr", {32'd0, bus32.o_instr}, 64'h00100093);
        check_eq("bp.hold_valid", {63'd0, bus32.o_valid}, 64'd1);
        bus32.i_ready = 1'b1;
        tick();
        check32("bp.second", 32'h00200093, 64'd2, 3'd1, 1'b0);
        check_eq("bp.ready1", {63'd0, bus32.o_ready}, 64'd1);
        tick();
        bus32.i_valid = 1'b0;
        check32("bp.third", 32'h00300093, 64'd3, 3'd1, 1'b0);
        tick();
        check_eq("bp.empty", {63'd0, bus32.o_valid}, 64'd0);

        // Illegal opcodes, third one flushed in its accept cycle
        push32(32'h0000007F, 1'b1); check32("ill1", 32'h0000007F, 64'd0, 3'd7, 1'b1);
        push32(32'h0000007F, 1'b1); check32("ill2", 32'h0000007F, 64'd0, 3'd7, 1'b1);
        bus32.i_flush = 1'b1;
        push32(32'h0000007F, 1'b1);
        bus32.i_flush = 1'b0;
        check_eq("ill3.valid", {63'd0, bus32.o_valid}, 64'd0);
        check_eq("ill3.cnt",   {48'd0, bus32.o_ill_cnt}, 64'd2);
        push32(32'h0000003B, 1'b1); check32("op32_rv32", 32'h0000003B, 64'd0, 3'd7, 1'b1);
        check_eq("op32_rv32.cnt", {48'd0, bus32.o_ill_cnt}, 64'd3);

        // Flush with both entries full
        bus32.i_ready = 1'b0;
        bus32.i_valid = 1'b1;
        bus32.i_instr = 32'h00500093;
        tick();
        tick();
        check_eq("fl.full", {63'd0, bus32.o_ready}, 64'd0);
        bus32.i_flush = 1'b1;
        tick();
        bus32.i_flush = 1'b0;
        bus32.i_valid = 1'b0;
        check_eq("fl.valid", {63'd0, bus32.o_valid}, 64'd0);
        check_eq("fl.ready", {63'd0, bus32.o_ready}, 64'd1);
        check_eq("fl.cnt",   {48'd0, bus32.o_ill_cnt}, 64'd3);
        bus32.i_ready = 1'b1;

        // Counter saturation with a 2-bit counter
        push_sat(32'h0000007F);
        push_sat(32'h0000007F);
        push_sat(32'h0000007F);
        check_eq("sat.three", {62'd0, bussat.o_ill_cnt}, 64'd3);
        push_sat(32'h0000007F);
        push_sat(32'h0000007F);
        check_eq("sat.hold", {62'd0, bussat.o_ill_cnt}, 64'd3);
        check_eq("sat.fmt",  {61'd0, bussat.o_fmt}, 64'd7);

        // RV64 decode
        push64(32'hFE000EE3, 1'b1); check64("beq64",  64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        push64(32'h43F0D093, 1'b1); check64("srai63", 64'd63, 3'd6, 1'b0);
        push64(32'h80000037, 1'b0); check64("lui64",  64'hFFFFFFFF80000000, 3'd4, 1'b0);
        push64(32'h03F0909B, 1'b1); check64("slliw",  64'd31, 3'd6, 1'b0);
        push64(32'hFFF0009B, 1'b1); check64("addiw",  64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        push64(32'h0000003B, 1'b1); check64("op32",   64'd0, 3'd0, 1'b0);
        check_eq("rv64.cnt", {48'd0, bus64.o_ill_cnt}, 64'd0);

        // Reset with both entries full
        bus32.i_ready = 1'b0;
        bus32.i_valid = 1'b1;
        bus32.i_instr = 32'h00700093;
        tick();
        tick();
        bus32.i_valid = 1'b0;
        check_eq("rf.full", {63'd0, bus32.o_ready}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rf.valid", {63'd0, bus32.o_valid}, 64'd0);
        check_eq("rf.ready", {63'd0, bus32.o_ready}, 64'd1);
        check_eq("rf.cnt",   {48'd0, bus32.o_ill_cnt}, 64'd0);
        check_eq("rf.instr", {32'd0, bus32.o_instr}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
